// File: rtl/nram_pkg.sv
// Shared definitions for the clearable scratch RAM: controller state encoding,
// the parity helper and the read-latency legality check.
package nram_pkg;

    // Controller states: INIT runs the clear engine, RUN accepts user accesses.
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } nram_state_t;

    // Widest data word the parity helper accepts; callers zero-extend into it.
    localparam int PAR_VEC_W = 64;

    // Even parity bit of a word: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [PAR_VEC_W-1:0] d);
        return ^d;
    endfunction

    // Only one or two cycles of read latency are implemented.
    function automatic bit rd_lat_legal(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/nram_clr_mux_core.sv
// Storage array with write-first bypass and a one- or two-stage read pipeline.
// Out-of-range writes are dropped; out-of-range reads return an all-zero word
// (data and parity bit both 0, so no parity error is flagged).
module nram_clr_mux_core
    import nram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int WORD_W = 8,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64,
    parameter int RD_LAT = 1,
    parameter bit PAR_EN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              ren,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] q,
    output logic              qvalid,
    output logic              perr
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    if (!rd_lat_legal(RD_LAT)) begin : g_bad_lat
        $error("nram_clr_mux_core: RD_LAT must be 1 or 2");
    end

    logic [WORD_W-1:0] mem_r [DEPTH];

    logic              wr_in_range_s;
    logic              rd_in_range_s;
    logic [WORD_W-1:0] rd_word_s;
    logic              fd_v_s;
    logic [WORD_W-1:0] fd_w_s;
    logic              fd_perr_s;

    logic [DATA_W-1:0] q_r;
    logic              qvalid_r;
    logic              perr_r;

    assign wr_in_range_s = ({1'b0, waddr} < DEPTH_L);
    assign rd_in_range_s = ({1'b0, raddr} < DEPTH_L);

    // Array write port; the array itself is cleared by the controller, not by reset.
    always_ff @(posedge clk) begin
        if (wen && wr_in_range_s) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read word selection: out-of-range -> zero, same-address write -> new data, else array.
    always_comb begin
        rd_word_s = '0;
        if (!rd_in_range_s) begin
            rd_word_s = '0;
        end else if (wen && (waddr == raddr)) begin
            rd_word_s = wdata;
        end else begin
            rd_word_s = mem_r[raddr];
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic              s1_v_r;
        logic [WORD_W-1:0] s1_w_r;

        // Extra pipeline stage; flushed by reset so in-flight reads vanish.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_v_r <= 1'b0;
                s1_w_r <= '0;
            end else begin
                s1_v_r <= ren;
                s1_w_r <= rd_word_s;
            end
        end

        assign fd_v_s = s1_v_r;
        assign fd_w_s = s1_w_r;
    end else begin : g_lat1
        assign fd_v_s = ren;
        assign fd_w_s = rd_word_s;
    end

    // With parity stored in the top bit, a good word XORs to zero across all bits.
    assign fd_perr_s = PAR_EN ? (^fd_w_s) : 1'b0;

    // Output stage: data held between reads, valid and parity flag pulse per read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r      <= '0;
            qvalid_r <= 1'b0;
            perr_r   <= 1'b0;
        end else begin
            qvalid_r <= fd_v_s;
            perr_r   <= fd_v_s & fd_perr_s;
            if (fd_v_s) begin
                q_r <= fd_w_s[DATA_W-1:0];
            end
        end
    end

    assign q      = q_r;
    assign qvalid = qvalid_r;
    assign perr   = perr_r;

endmodule

// File: rtl/nram_clr_mux.sv
// Clearable single-clock scratch RAM. After reset, or when io_CLR is seen in RUN,
// the clear engine writes zero to every word (one per cycle) before accesses
// are accepted again. Optional feature macro: NRAM_PARITY_EN adds a stored
// even-parity bit per word, with error injection via io_PINJ and checking on io_PERR.
module nram_clr_mux
    import nram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] io_D,
    input  logic [ADDR_W-1:0] io_WADD,
    input  logic              io_WEN,
    input  logic [ADDR_W-1:0] io_RADD,
    input  logic              io_REN,
    input  logic              io_CLR,
    input  logic              io_PINJ,
    output logic [DATA_W-1:0] io_Q,
    output logic              io_QVALID,
    output logic              io_READY,
    output logic              io_PERR
);

`ifdef NRAM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int WORD_W = DATA_W;
    localparam bit PAR_EN = 1'b0;
`endif

    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);

    nram_state_t       state_r;
    nram_state_t       state_nxt_s;
    logic [ADDR_W-1:0] clr_cnt_r;
    logic [ADDR_W-1:0] clr_cnt_nxt_s;
    logic              ready_r;
    logic              clr_last_s;

    logic [WORD_W-1:0] user_word_s;
    logic              core_wen_s;
    logic [ADDR_W-1:0] core_waddr_s;
    logic [WORD_W-1:0] core_wdata_s;
    logic              core_ren_s;

`ifdef NRAM_PARITY_EN
    assign user_word_s = {even_parity(PAR_VEC_W'(io_D)) ^ io_PINJ, io_D};
`else
    logic unused_pinj_s;
    assign user_word_s   = io_D;
    assign unused_pinj_s = io_PINJ;
`endif

    assign clr_last_s = ({1'b0, clr_cnt_r} == LAST_ADDR);

    // State, clear counter and READY registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_INIT;
            clr_cnt_r <= '0;
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            clr_cnt_r <= clr_cnt_nxt_s;
            ready_r   <= (state_nxt_s == ST_RUN);
        end
    end

    // Next state and next clear address: INIT leaves after writing the last word.
    always_comb begin
        state_nxt_s   = state_r;
        clr_cnt_nxt_s = '0;
        case (state_r)
            ST_INIT: begin
                if (clr_last_s) begin
                    state_nxt_s   = ST_RUN;
                    clr_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s   = ST_INIT;
                    clr_cnt_nxt_s = clr_cnt_r + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                clr_cnt_nxt_s = '0;
                if (io_CLR) begin
                    state_nxt_s = ST_INIT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s   = ST_INIT;
                clr_cnt_nxt_s = '0;
            end
        endcase
    end

    // Array port mux: the clear engine owns the write port in INIT, the user in RUN.
    always_comb begin
        core_wen_s   = 1'b0;
        core_waddr_s = '0;
        core_wdata_s = '0;
        core_ren_s   = 1'b0;
        case (state_r)
            ST_INIT: begin
                core_wen_s   = 1'b1;
                core_waddr_s = clr_cnt_r;
                core_wdata_s = '0;
                core_ren_s   = 1'b0;
            end
            ST_RUN: begin
                core_wen_s   = io_WEN;
                core_waddr_s = io_WADD;
                core_wdata_s = user_word_s;
                core_ren_s   = io_REN;
            end
            default: begin
                core_wen_s   = 1'b0;
                core_waddr_s = '0;
                core_wdata_s = '0;
                core_ren_s   = 1'b0;
            end
        endcase
    end

    nram_clr_mux_core #(
        .DATA_W (DATA_W),
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT),
        .PAR_EN (PAR_EN)
    ) u_core (
        .clk    (clk),
        .rst    (reset),
        .wen    (core_wen_s),
        .waddr  (core_waddr_s),
        .wdata  (core_wdata_s),
        .ren    (core_ren_s),
        .raddr  (io_RADD),
        .q      (io_Q),
        .qvalid (io_QVALID),
        .perr   (io_PERR)
    );

    assign io_READY = ready_r;

endmodule
